// File: rtl/mips_pkg.sv
// mips_pkg: op encodings, FSM states and constants shared by the multiply/divide unit
package mips_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int ITERS = 32;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: sequencing FSM, iteration counter and busy/done/div_by_zero strobes
// MULT_DIV_FAST_MUL_EN: multiplies leave CALC after a single cycle
module mult_div_ctrl
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start_i,
  input  logic   div_zero_i,
`ifdef MULT_DIV_FAST_MUL_EN
  input  logic   mul_i,
`endif
  output state_e state_o,
  output logic   zero_o,
  output logic   busy_o,
  output logic   done_o,
  output logic   div_by_zero_o
);
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic zero_q, zero_d, last;
`ifdef MULT_DIV_FAST_MUL_EN
  assign last = mul_i || cnt_q == 6'(ITERS - 1);
`else
  assign last = cnt_q == 6'(ITERS - 1);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = div_zero_i ? FIX : CALC;
        zero_d = div_zero_i;
      end
      CALC: begin
        state_d = last ? FIX : CALC;
        cnt_d = cnt_q + 6'd1;
      end
      FIX: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      zero_q <= zero_d;
    end
  end
  assign state_o = state_q;
  assign zero_o = zero_q;
  assign busy_o = state_q == CALC || state_q == FIX;
  assign done_o = state_q == DONE;
  assign div_by_zero_o = done_o && zero_q;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS HI/LO multiply/divide unit with MTHI/MTLO moves
// MULT_DIV_FAST_MUL_EN: a single-cycle multiplier replaces the shift-add loop
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] move_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int W2 = 2 * WIDTH;
  state_e state;
  logic zero, idle, accept, sgn, is_div, div_zero, sa, sb;
  logic div_q, div_d, neg_q, neg_d, nrem_q, nrem_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b, quo, rem;
  logic [W2-1:0] acc_q, acc_d, dstep, prod, pfix;
  logic [WIDTH:0] rsh, dsub;
  assign idle = state == IDLE;
  assign accept = idle && start_i;
  assign sgn = op_i == OP_MULT || op_i == OP_DIV;
  assign is_div = op_i == OP_DIV || op_i == OP_DIVU;
  assign div_zero = is_div && rt_data_i == '0;
  assign sa = sgn && rs_data_i[WIDTH-1];
  assign sb = sgn && rt_data_i[WIDTH-1];
  assign mag_a = sa ? -rs_data_i : rs_data_i;
  assign mag_b = sb ? -rt_data_i : rt_data_i;
  // acc holds {remainder, quotient} for divide and {high, low/multiplier} for multiply
  assign rsh = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign dsub = rsh - {1'b0, b_q};
  assign dstep = dsub[WIDTH] ? {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`ifdef MULT_DIV_FAST_MUL_EN
  assign prod = W2'(a_q) * W2'(b_q);
`else
  logic [WIDTH:0] msum;
  assign msum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign prod = {msum, acc_q[WIDTH-1:1]};
`endif
  assign pfix = neg_q ? -acc_q : acc_q;
  assign quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = nrem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    div_d = div_q;
    neg_d = neg_q;
    nrem_d = nrem_q;
    acc_d = acc_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept) begin
      a_d = mag_a;
      b_d = mag_b;
      div_d = is_div;
      neg_d = sa ^ sb;
      nrem_d = sa;
      acc_d = div_zero ? {rs_data_i, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
    end else if (idle) begin
      hi_d = hi_we_i ? move_data_i : hi_q;
      lo_d = lo_we_i ? move_data_i : lo_q;
    end
    if (state == CALC) acc_d = div_q ? dstep : prod;
    if (state == FIX) begin
      hi_d = zero ? acc_q[W2-1:WIDTH] : div_q ? rem : pfix[W2-1:WIDTH];
      lo_d = zero ? acc_q[WIDTH-1:0] : div_q ? quo : pfix[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      nrem_q <= 1'b0;
      acc_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      div_q <= div_d;
      neg_q <= neg_d;
      nrem_q <= nrem_d;
      acc_q <= acc_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  mult_div_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .div_zero_i   (div_zero),
`ifdef MULT_DIV_FAST_MUL_EN
    .mul_i        (!div_q),
`endif
    .state_o      (state),
    .zero_o       (zero),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .div_by_zero_o(div_by_zero_o)
  );
endmodule
